// File: rtl/tt_um_project_pkg.sv
// rtl/tt_um_project_pkg.sv - shared types and constants for the accumulator ALU
package tt_um_project_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_SHR  = 3'd7
    } op_t;

    // Bit positions of the status flags on uio_out
    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 5;
    localparam int FLAG_N = 6;
    localparam int FLAG_V = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_project_alu.sv
// rtl/tt_um_project_alu.sv - combinational 8-bit ALU producing result and Z/C/N/V
module tt_um_project_alu
    import tt_um_project_pkg::*;
(
    input  logic [7:0] acc,
    input  logic [7:0] d,
    input  op_t        op,
    output logic [7:0] r,
    output logic       z,
    output logic       c,
    output logic       n,
    output logic       v
);

    logic [8:0] sum9;
    logic [8:0] diff9;

    // Result and carry/overflow per opcode; Z and N derive from the result alone
    always_comb begin
        sum9  = {1'b0, acc} + {1'b0, d};
        diff9 = {1'b0, acc} - {1'b0, d};
        r     = 8'h00;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            OP_LOAD: r = d;
            OP_ADD: begin
                r = sum9[7:0];
                c = sum9[8];
                v = (acc[7] == d[7]) && (sum9[7] != acc[7]);
            end
            OP_SUB: begin
                r = diff9[7:0];
                // The ninth bit of the widened difference is the borrow (acc < d)
                c = diff9[8];
                v = (acc[7] != d[7]) && (diff9[7] != acc[7]);
            end
            OP_AND: r = acc & d;
            OP_OR:  r = acc | d;
            OP_XOR: r = acc ^ d;
            OP_SHL: begin
                r = {acc[6:0], 1'b0};
                c = acc[7];
            end
            OP_SHR: begin
                r = {1'b0, acc[7:1]};
                c = acc[0];
            end
            default: r = 8'h00;
        endcase
        z = (r == 8'h00);
        n = r[7];
    end

endmodule

// File: rtl/tt_um_project_top.sv
// rtl/tt_um_project_top.sv - Tiny Tapeout wrapper: strobe edge detect, ACC/flag registers, pin map
module tt_um_project_top
    import tt_um_project_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic       strb_q, strb_d;
    logic [7:0] acc_q, acc_d;
    logic       z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
    logic       fire;

    logic [7:0] alu_r;
    logic       alu_z, alu_c, alu_n, alu_v;

    // Upper uio inputs carry nothing for this design
    wire unused_sink = &{1'b0, uio_in[7:4], 1'b0};

    tt_um_project_alu u_alu (
        .acc (acc_q),
        .d   (ui_in),
        .op  (op_t'(uio_in[2:0])),
        .r   (alu_r),
        .z   (alu_z),
        .c   (alu_c),
        .n   (alu_n),
        .v   (alu_v)
    );

    // Rising strobe while selected executes one command; strobe history tracks every cycle
    always_comb begin
        fire   = ena && uio_in[3] && !strb_q;
        strb_d = uio_in[3];
        acc_d  = acc_q;
        z_d    = z_q;
        c_d    = c_q;
        n_d    = n_q;
        v_d    = v_q;
        if (fire) begin
            acc_d = alu_r;
            z_d   = alu_z;
            c_d   = alu_c;
            n_d   = alu_n;
            v_d   = alu_v;
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= 1'b0;
            acc_q  <= 8'h00;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            strb_q <= strb_d;
            acc_q  <= acc_d;
            z_q    <= z_d;
            c_q    <= c_d;
            n_q    <= n_d;
            v_q    <= v_d;
        end
    end

    // Pin mapping
    always_comb begin
        uo_out          = acc_q;
        uio_out         = 8'h00;
        uio_out[FLAG_Z] = z_q;
        uio_out[FLAG_C] = c_q;
        uio_out[FLAG_N] = n_q;
        uio_out[FLAG_V] = v_q;
        uio_oe          = UIO_OE_VAL;
    end

endmodule

// File: tb/tb_tt_um_project_top.sv
// tb/tb_tt_um_project_top.sv - directed scoreboard bench for the accumulator ALU
module tb_tt_um_project_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [7:0]  m_acc;
    logic        m_z, m_c, m_n, m_v;

    tt_um_project_top dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built from integer arithmetic
    task automatic model_step(input logic [2:0] op, input logic [7:0] d);
        int ua, ud, us, sa, sd, ss;
        logic [7:0] r;
        ua = int'(m_acc);
        ud = int'(d);
        sa = (ua > 127) ? ua - 256 : ua;
        sd = (ud > 127) ? ud - 256 : ud;
        m_c = 1'b0;
        m_v = 1'b0;
        case (op)
            3'd0: r = d;
            3'd1: begin
                us = ua + ud; r = us[7:0]; m_c = (us > 255);
                ss = sa + sd; m_v = (ss > 127) || (ss < -128);
            end
            3'd2: begin
                us = ua - ud + 256; r = us[7:0]; m_c = (ua < ud);
                ss = sa - sd; m_v = (ss > 127) || (ss < -128);
            end
            3'd3: r = m_acc & d;
            3'd4: r = m_acc | d;
            3'd5: r = m_acc ^ d;
            3'd6: begin us = ua * 2; r = us[7:0]; m_c = (ua >= 128); end
            default: begin us = ua / 2; r = us[7:0]; m_c = (ua % 2 == 1); end
        endcase
        m_acc = r;
        m_z = (r == 8'h00);
        m_n = (r >= 8'h80);
    endtask

    function automatic logic [15:0] model_pins();
        return {m_acc, m_v, m_n, m_c, m_z, 4'h0};
    endfunction

    // Drive one strobe pulse, score the result, then return the strobe low for a cycle
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d);
        logic [15:0] exp;
        @(negedge clk);
        ui_in  = d;
        uio_in = {4'b1010, 1'b1, op};
        model_step(op, d);
        sb.push_back(model_pins());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            exp = sb.pop_front();
            check("cmd", {uo_out, uio_out}, exp);
        end
        @(negedge clk);
        uio_in[3] = 1'b0;
        ui_in     = 8'($urandom);
        uio_in[2:0] = 3'($urandom);
        @(posedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h5A;
        uio_in = 8'h0B;
        m_acc = 8'h00; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pins", {uo_out, uio_out}, 16'h0000);
        check("reset_oe", {8'h00, uio_oe}, 16'h00F0);
        @(negedge clk);
        uio_in = 8'h00;
        rst_n  = 1'b1;
        @(posedge clk);

        // LOAD and ADD with carry / overflow
        do_cmd(3'd0, 8'hF0);
        do_cmd(3'd1, 8'h20);
        check("add_carry", {uo_out, uio_out}, {8'h10, 8'h20});
        do_cmd(3'd1, 8'h70);
        check("add_ovf", {uo_out, uio_out}, {8'h80, 8'hC0});

        // SUB to zero, then borrow
        do_cmd(3'd0, 8'h05);
        do_cmd(3'd2, 8'h05);
        check("sub_zero", {uo_out, uio_out}, {8'h00, 8'h10});
        do_cmd(3'd2, 8'h01);
        check("sub_borrow", {uo_out, uio_out}, {8'hFF, 8'h60});

        // Logic and shifts
        do_cmd(3'd0, 8'hAA);
        do_cmd(3'd5, 8'hFF);
        check("xor", {uo_out, uio_out}, {8'h55, 8'h00});
        do_cmd(3'd6, 8'h00);
        check("shl", {uo_out, uio_out}, {8'hAA, 8'h40});
        do_cmd(3'd7, 8'h00);
        check("shr1", {uo_out, uio_out}, {8'h55, 8'h00});
        do_cmd(3'd7, 8'h00);
        check("shr2", {uo_out, uio_out}, {8'h2A, 8'h20});
        do_cmd(3'd3, 8'h0F);
        do_cmd(3'd4, 8'h81);
        do_cmd(3'd2, 8'h90);

        // Strobe held high five cycles executes once
        do_cmd(3'd0, 8'h00);
        @(negedge clk);
        ui_in  = 8'h01;
        uio_in = 8'h09;
        model_step(3'd1, 8'h01);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_once", {uo_out, uio_out}, {8'h01, 8'h00});
        end
        @(negedge clk);
        uio_in = 8'h00;
        @(posedge clk);

        // Strobe rising while deselected is lost, not deferred
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'hEE;
        uio_in = 8'h08;
        @(posedge clk);
        #1;
        check("ena_low", {uo_out, uio_out}, model_pins());
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("not_deferred", {uo_out, uio_out}, {8'h01, 8'h00});
        @(negedge clk);
        uio_in = 8'h00;
        @(posedge clk);

        // Asynchronous reset mid-run
        do_cmd(3'd0, 8'h3C);
        check("load_3c", {uo_out, uio_out}, {8'h3C, 8'h00});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {uo_out, uio_out}, 16'h0000);
        check("oe_in_reset", {8'h00, uio_oe}, 16'h00F0);

        // Strobe already high at reset release counts as a rising edge
        ui_in  = 8'h77;
        uio_in = 8'h08;
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 8'h00; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        model_step(3'd0, 8'h77);
        sb.push_back(model_pins());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            check("strobe_at_release", {uo_out, uio_out}, sb.pop_front());
        end
        check("strobe_at_release_val", {uo_out, uio_out}, {8'h77, 8'h00});
        @(negedge clk);
        uio_in = 8'h00;
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
